// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count, run-time threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through read data; otherwise data_out is registered on pop.
module fifo_param #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    input  logic [AW:0]       af_th,
    input  logic [AW:0]       ae_th,
    input  logic              err_clr,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              err_overflow,
    output logic              err_underflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_th);
    assign almost_empty = (count <= ae_th);

    // Acceptance looks only at the registered occupancy, so a pop never makes room for a same-cycle push.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);

            if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);

            if (push && full)  err_overflow <= 1'b1;
            else if (err_clr)  err_overflow <= 1'b0;

            if (pop && empty)  err_underflow <= 1'b1;
            else if (err_clr)  err_underflow <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk) begin
        if (reset)       data_out <= '0;
        else if (pop_ok) data_out <= mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table vectors, directed corner sequences and random traffic against a queue model of fifo_param.
// Build with FIFO_FWFT_EN defined to check the fall-through read mode.
module tb_fifo_param;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [AW:0]   af_th = 4'd6;
    logic [AW:0]   ae_th = 4'd2;
    logic          full, empty, almost_full, almost_empty, err_overflow, err_underflow;
    logic [AW:0]   count;

    fifo_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .af_th(af_th), .ae_th(ae_th), .err_clr(err_clr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue of stored words plus the last word handed out.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        int exp_dout;
        n = q.size();
        if (FWFT) exp_dout = (n != 0) ? int'(q[0]) : 0;
        else      exp_dout = int'(m_dout);
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= int'(ae_th)));
        chk({tag, ".almost_full"}, int'(almost_full), int'(n >= int'(af_th)));
        chk({tag, ".err_overflow"}, int'(err_overflow), int'(m_ovf));
        chk({tag, ".err_underflow"}, int'(err_underflow), int'(m_unf));
        chk({tag, ".data_out"}, int'(data_out), exp_dout);
    endtask

    task automatic cycle(input bit p, input bit o, input logic [DW-1:0] d, input bit c, input string tag);
        int n;
        push = p; pop = o; data_in = d; err_clr = c;
        n = q.size();
        if (p && n == DEPTH) m_ovf = 1'b1;
        else if (c)          m_ovf = 1'b0;
        if (o && n == 0)     m_unf = 1'b1;
        else if (c)          m_unf = 1'b0;
        if (o && n != 0) m_dout = q.pop_front();
        if (p && n != DEPTH) q.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        compare_model(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        q.delete();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_model(tag);
    endtask

    typedef struct {
        bit            push;
        bit            pop;
        bit            clr;
        logic [DW-1:0] din;
        int            cnt;
        bit            emp, ful, ae, af, ovf, unf;
        int            dout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit p, bit o, bit c, logic [DW-1:0] d, int cnt,
                                bit emp, bit ful, bit ae, bit af, bit ovf, bit unf, int dout);
        vec_t v;
        v.push = p; v.pop = o; v.clr = c; v.din = d; v.cnt = cnt;
        v.emp = emp; v.ful = ful; v.ae = ae; v.af = af; v.ovf = ovf; v.unf = unf; v.dout = dout;
        vecs.push_back(v);
    endfunction

    initial begin
        int c;
        int exp;
        logic [DW-1:0] w;

        // Fill from empty, overflow, drain in order, underflow, then clear.
        for (int i = 1; i <= 8; i++)
            add(1, 0, 0, DW'(i), i, 0, i == 8, i <= 2, i >= 6, 0, 0, FWFT ? 1 : 0);
        add(1, 0, 0, 12'hABC, 8, 0, 1, 0, 1, 1, 0, FWFT ? 1 : 0);
        for (int i = 1; i <= 8; i++) begin
            c = 8 - i;
            add(0, 1, 0, '0, c, c == 0, 0, c <= 2, c >= 6, 1, 0, FWFT ? ((i < 8) ? i + 1 : 0) : i);
        end
        add(0, 1, 0, '0, 0, 1, 0, 1, 0, 1, 1, FWFT ? 0 : 8);
        add(0, 0, 1, '0, 0, 1, 0, 1, 0, 0, 0, FWFT ? 0 : 8);

        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");
        chk("reset.count_const", int'(count), 0);
        chk("reset.empty_const", int'(empty), 1);
        chk("reset.data_out_const", int'(data_out), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr, t);
            chk({t, ".cnt_t"}, int'(count), vecs[i].cnt);
            chk({t, ".emp_t"}, int'(empty), int'(vecs[i].emp));
            chk({t, ".ful_t"}, int'(full), int'(vecs[i].ful));
            chk({t, ".ae_t"}, int'(almost_empty), int'(vecs[i].ae));
            chk({t, ".af_t"}, int'(almost_full), int'(vecs[i].af));
            chk({t, ".ovf_t"}, int'(err_overflow), int'(vecs[i].ovf));
            chk({t, ".unf_t"}, int'(err_underflow), int'(vecs[i].unf));
            chk({t, ".dout_t"}, int'(data_out), vecs[i].dout);
        end

        // Steady occupancy of 4 with simultaneous push/pop across several pointer wraps.
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 0, "wrap_fill");
        for (int i = 0; i < 4; i++) cycle(0, 1, '0, 0, "wrap_drain");
        for (int i = 0; i < 4; i++) cycle(1, 0, DW'(12'h100 + i), 0, "wrap_pre");
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, DW'(12'h104 + i), 0, "wrap");
            chk("wrap.count4", int'(count), 4);
            exp = FWFT ? 12'h101 + i : 12'h100 + i;
            chk("wrap.order", int'(data_out), exp);
        end

        // Full with push+pop: pop wins, push dropped.
        for (int i = 0; i < 4; i++) cycle(1, 0, DW'(12'h200 + i), 0, "full_fill");
        cycle(1, 1, 12'h7FF, 0, "full_pp");
        chk("full_pp.count7", int'(count), 7);
        chk("full_pp.ovf", int'(err_overflow), 1);
        while (q.size() != 0) cycle(0, 1, '0, 0, "full_drain");
        cycle(0, 0, '0, 1, "clr");
        // Empty with push+pop: push accepted, pop rejected.
        cycle(1, 1, 12'h055, 0, "empty_pp");
        chk("empty_pp.count1", int'(count), 1);
        chk("empty_pp.unf", int'(err_underflow), 1);
        // err_clr together with a new error: set wins.
        cycle(1, 0, 12'h056, 0, "setwin_fill");
        cycle(0, 1, '0, 0, "setwin_pop1");
        cycle(0, 1, '0, 0, "setwin_pop2");
        cycle(0, 1, '0, 1, "setwin");
        chk("setwin.unf", int'(err_underflow), 1);

        // Reset discards queued words; then a fresh word round-trips.
        for (int i = 0; i < 5; i++) cycle(1, 0, DW'(12'h300 + i), 0, "pre_rst");
        do_reset("mid_reset");
        chk("mid_reset.count", int'(count), 0);
        chk("mid_reset.empty", int'(empty), 1);
        chk("mid_reset.dout", int'(data_out), 0);
        cycle(1, 0, 12'h3C3, 0, "rt_push");
        chk("rt_push.dout", int'(data_out), FWFT ? 12'h3C3 : 0);
        cycle(0, 1, '0, 0, "rt_pop");
        chk("rt_pop.dout", int'(data_out), FWFT ? 0 : 12'h3C3);

        // Random traffic with run-time thresholds, error clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                af_th = 4'($urandom_range(0, 15));
                ae_th = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end else begin
                w = DW'($urandom);
                cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, w,
                      $urandom_range(0, 19) == 0, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
